// File: rtl/la_cmd_rx.sv
// UART 8N1 receiver with SUMP short/long command assembly; execute/frame_err one cycle after the final stop-bit sample.
// No backpressure: strobes are fire-and-forget, and cmd holds the last completed command.
module la_cmd_rx #(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD_BASE      = 115200,
    parameter int CMD_BYTES      = 5,
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx,
    input  logic [1:0]             speed,
    output logic [8*CMD_BYTES-1:0] cmd,
    output logic                   execute,
    output logic                   frame_err,
    output logic                   busy
);
    localparam int BASE_DIV = (CLK_FREQ + BAUD_BASE * 8) / (BAUD_BASE * 16);
    localparam int DIV_W    = $clog2(BASE_DIV * 6 + 1);
    localparam int TO_TICKS = TIMEOUT_FRAMES * 160;
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [1:0]             warm;
    logic [1:0]             spd_q;
    logic [DIV_W-1:0]       div_cnt, div_val;
    logic                   tick;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic [IDX_W-1:0]       idx;
    logic [8*CMD_BYTES-1:0] shadow, asm_nxt;
    logic [TO_W-1:0]        to_cnt;
    logic                   start_edge, stop_sample;

    always_comb begin
        case (spd_q)
            2'd0:    div_val = DIV_W'(BASE_DIV);
            2'd1:    div_val = DIV_W'(BASE_DIV * 2);
            2'd2:    div_val = DIV_W'(BASE_DIV * 3);
            default: div_val = DIV_W'(BASE_DIV * 6);
        endcase
    end

    assign tick        = (div_cnt == div_val - 1'b1);
    // rx_prev only goes high once rx_s2 holds a real line sample, so a line held low through reset is never a start
    assign start_edge  = (state == S_IDLE) && rx_prev && !rx_s2;
    assign stop_sample = (state == S_STOP) && tick && (tick_cnt == 4'd15);
    assign busy        = (state != S_IDLE) || (idx != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b0;
            warm     <= 2'b00;
            state    <= S_IDLE;
            spd_q    <= 2'd0;
            div_cnt  <= '0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            warm    <= {warm[0], 1'b1};
            rx_prev <= warm[1] & rx_s2;

            if (start_edge || tick) div_cnt <= '0;
            else                    div_cnt <= div_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_START;
                        spd_q    <= speed;
                        tick_cnt <= 4'd0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            bit_cnt  <= 3'd0;
                            state    <= rx_s2 ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= 4'd0;
                            shift    <= {rx_s2, shift[7:1]};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (tick_cnt == 4'd15) begin
                            tick_cnt <= 4'd0;
                            state    <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        asm_nxt = shadow;
        for (int k = 0; k < CMD_BYTES; k++) begin
            if (idx == IDX_W'(k)) asm_nxt[8*k +: 8] = shift;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd       <= '0;
            execute   <= 1'b0;
            frame_err <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
            to_cnt    <= '0;
        end else begin
            execute   <= 1'b0;
            frame_err <= 1'b0;

            if (stop_sample) begin
                if (!rx_s2) begin
                    frame_err <= 1'b1;
                    idx       <= '0;
                end else if (idx == '0 && !shift[7]) begin
                    cmd     <= {{(8*CMD_BYTES-8){1'b0}}, shift};
                    execute <= 1'b1;
                end else if (idx == IDX_W'(CMD_BYTES - 1)) begin
                    cmd     <= asm_nxt;
                    execute <= 1'b1;
                    idx     <= '0;
                end else begin
                    shadow <= asm_nxt;
                    idx    <= idx + 1'b1;
                end
            end

            // Inter-byte timeout counts idle ticks of the last frame's rate; a start edge pre-empts it
            if (state == S_IDLE && idx != '0 && !start_edge) begin
                if (tick) begin
                    if (to_cnt == TO_W'(TO_TICKS - 1)) begin
                        to_cnt <= '0;
                        idx    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end
endmodule
